// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock synchronous FIFO, parametrised width/depth.
//
// Optional feature macro: FIFO_FWFT_EN
//   undefined (default): registered read, dout valid one cycle after an
//                        accepted rd_en and held otherwise.
//   defined            : first-word-fall-through, dout = head entry while
//                        !empty, rd_en pops with zero latency.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   wr_en, din   in   write request / data
//   rd_en        in   read request (pop in FWFT mode)
//   dout         out  read data
//   full, empty  out  count == DEPTH / count == 0 (registered)
//   almost_full  out  count >= AF_THRESH (registered)
//   almost_empty out  count <= AE_THRESH (registered)
//   count        out  occupancy 0..DEPTH
//   overflow     out  one-cycle pulse after a rejected write
//   underflow    out  one-cycle pulse after a rejected read
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LIM  = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LIM  = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, afull_q, aempty_q;
  logic          ovf_q, udf_q;
  logic          wr_acc, rd_acc;

  // Acceptance uses the registered flags, i.e. the state before the edge.
  always_comb begin
    wr_acc  = wr_en && !full_q;
    rd_acc  = rd_en && !empty_q;
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q  <= count_d;
      // Flags come from next-state count so they line up with count.
      full_q   <= (count_d == CNT_MAX);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AF_LIM);
      aempty_q <= (count_d <= AE_LIM);
      ovf_q    <= wr_en && !wr_acc;
      udf_q    <= rd_en && !rd_acc;
    end
  end

  // Storage is never cleared; the pointer reset alone discards contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr_q] <= din;
  end

`ifdef FIFO_FWFT_EN
  assign dout = mem[rd_ptr_q];
`else
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst)         dout_q <= '0;
    else if (rd_acc) dout_q <= mem[rd_ptr_q];
  end

  assign dout = dout_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param (WIDTH=8, DEPTH=8, AF=6, AE=2).
// A queue-based model predicts every output; directed phases add literal
// expectations, followed by randomized traffic with occasional resets.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [W-1:0] din = '0;
  logic         rd_en = 1'b0;
  logic [W-1:0] dout;
  logic         full, empty, almost_full, almost_empty;
  logic [3:0]   count;
  logic         overflow, underflow;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] q[$];
  logic [W-1:0] exp_dout = '0;
  bit           exp_ovf = 0, exp_udf = 0;
  bit           model_valid = 0;
  bit           do_rd, do_wr;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      exp_dout    = '0;
      exp_ovf     = 0;
      exp_udf     = 0;
      model_valid = 1;
    end else begin
      do_rd   = rd_en && (q.size() != 0);
      do_wr   = wr_en && (q.size() != D);
      exp_ovf = wr_en && !do_wr;
      exp_udf = rd_en && !do_rd;
      if (do_rd) exp_dout = q.pop_front();
      if (do_wr) q.push_back(din);
    end
  end

  // Compare process: all outputs, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("m_count", int'(count), q.size());
      chk("m_full", int'(full), int'(q.size() == D));
      chk("m_empty", int'(empty), int'(q.size() == 0));
      chk("m_afull", int'(almost_full), int'(q.size() >= AF));
      chk("m_aempty", int'(almost_empty), int'(q.size() <= AE));
      chk("m_overflow", int'(overflow), int'(exp_ovf));
      chk("m_underflow", int'(underflow), int'(exp_udf));
`ifdef FIFO_FWFT_EN
      if (q.size() != 0) chk("m_dout_fwft", int'(dout), int'(q[0]));
`else
      chk("m_dout", int'(dout), int'(exp_dout));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit w, input logic [W-1:0] d, input bit r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    cyc(0, '0, 0);
    rst = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);

`ifndef FIFO_FWFT_EN
    chk("rst_dout", int'(dout), 0);

    // 1: five writes then five reads
    for (int i = 0; i < 5; i++) cyc(1, W'(8'h11 + i), 0);
    chk("p1_count5", int'(count), 5);
    for (int i = 0; i < 5; i++) begin
      cyc(0, '0, 1);
      chk("p1_dout", int'(dout), 8'h11 + i);
    end
    chk("p1_count0", int'(count), 0);
    chk("p1_empty", int'(empty), 1);

    // 2: fill, almost_full threshold, overflow
    for (int i = 0; i < 8; i++) begin
      cyc(1, W'(8'hA0 + i), 0);
      chk("p2_afull", int'(almost_full), int'(i + 1 >= 6));
    end
    chk("p2_full", int'(full), 1);
    chk("p2_count8", int'(count), 8);
    cyc(1, 8'hFF, 0);
    chk("p2_ovf", int'(overflow), 1);
    chk("p2_count_hold", int'(count), 8);
    cyc(0, '0, 0);
    chk("p2_ovf_clear", int'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, '0, 1);
      chk("p2_dout", int'(dout), 8'hA0 + i);
    end

    // 3: underflow, simultaneous rd+wr on empty
    cyc(0, '0, 1);
    chk("p3_udf", int'(underflow), 1);
    chk("p3_dout_hold", int'(dout), 8'hA7);
    chk("p3_count0", int'(count), 0);
    cyc(1, 8'h3C, 1);
    chk("p3_count1", int'(count), 1);
    chk("p3_udf2", int'(underflow), 1);
    cyc(0, '0, 1);
    chk("p3_dout", int'(dout), 8'h3C);

    // 4: steady-state rd+wr across pointer wrap
    for (int i = 0; i < 4; i++) cyc(1, W'(i), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, W'(4 + i), 1);
      chk("p4_count", int'(count), 4);
      chk("p4_dout", int'(dout), i);
    end

    // 5: reset mid-stream with wr_en high
    cyc(1, 8'h40, 0);
    chk("p5_count5", int'(count), 5);
    rst = 1'b1;
    cyc(1, 8'h99, 0);
    rst = 1'b0;
    chk("p5_count", int'(count), 0);
    chk("p5_empty", int'(empty), 1);
    chk("p5_dout", int'(dout), 0);
    chk("p5_ovf", int'(overflow), 0);
    cyc(1, 8'h5A, 0);
    cyc(0, '0, 1);
    chk("p5_dout5a", int'(dout), 8'h5A);
`else
    // 6: fall-through visibility and zero-latency pop
    cyc(1, 8'h77, 0);
    chk("p6_dout", int'(dout), 8'h77);
    chk("p6_empty0", int'(empty), 0);
    cyc(0, '0, 1);
    chk("p6_empty1", int'(empty), 1);
`endif

    // Randomized traffic with varying write/read bias and rare resets
    for (int blk = 0; blk < 30; blk++) begin
      int unsigned pw = $urandom_range(10, 90);
      int unsigned pr = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        rst = ($urandom_range(0, 299) == 0);
        cyc($urandom_range(0, 99) < pw, W'($urandom), $urandom_range(0, 99) < pr);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock synchronous FIFO, parametrised successor to the team's fixed 8-bit FIFO. Generalised data width and depth. Adds occupancy count, programmable almost-full/almost-empty thresholds, and sticky-free overflow/underflow error pulses. Sits between producer and consumer blocks in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
Derived: AW = $clog2(DEPTH); count width AW+1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset; one clock; reset is synchronous and active-high
wr_en  input  1  write request
din  input  WIDTH  write data, sampled with wr_en
rd_en  input  1  read request
dout  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  AW+1  current occupancy 0..DEPTH
overflow  output  1  one-cycle pulse: write rejected
underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, dout=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Memory contents are not cleared. Reset overrides any concurrent rd_en/wr_en. Reset mid-stream discards all stored data.
- Accept rules: write accepted iff wr_en && !full. Read accepted iff rd_en && !empty. Both use flag values from before the edge.
- Write: mem[wr_ptr] <= din, wr_ptr <= wr_ptr+1 (wraps mod DEPTH).
- Read (standard mode): dout <= mem[rd_ptr] on the accepting edge, so data appears 1 cycle after rd_en. rd_ptr increments and wraps mod DEPTH. dout holds its value when no read is accepted.
- Count:
  - +1 on write only; -1 on read only.
  - Unchanged on simultaneous accepted read+write, or when neither is accepted.
- Simultaneous rd+wr:
  - Empty: write accepted, read rejected (underflow pulses). Count goes to 1.
  - Full: read accepted, write rejected (overflow pulses). Count goes to DEPTH-1.
  - Otherwise both accepted; count unchanged.
- All status outputs (full, empty, almost_*, count) are registered and derived from next-state count, so they are valid the cycle after the causing edge.
- overflow/underflow are registered and high for exactly one cycle after each rejected request. Back-to-back rejections hold them high continuously.
- Pointer wrap: after DEPTH writes and DEPTH reads the data order is preserved across the wrap boundary.

Optional Feature:
FIFO_FWFT_EN. When defined, the FIFO runs in first-word-fall-through mode:
- dout shows the head entry combinationally from mem[rd_ptr] whenever !empty.
- rd_en acts as a pop/acknowledge; read latency is 0.
- dout is don't-care while empty.
- Accept rules, flags, count and error pulses are identical to standard mode.

When not defined, standard registered-read mode applies as described above.

Test Plan:
(WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2 unless noted)
1. Reset, then write 0x11..0x15 (5 writes), then 5 reads -> dout sequence 0x11..0x15, each 1 cycle after rd_en. count goes 0→5→0. Ends with empty=1.
2. Write 8 words 0xA0..0xA7 -> full=1, count=8, almost_full=1 from count 6. 9th write 0xFF -> overflow=1 for one cycle, count stays 8. Then 8 reads return 0xA0..0xA7 and 0xFF never appears.
3. Read on empty FIFO -> underflow=1 for one cycle, dout unchanged, count=0. Then rd+wr together while empty with din=0x3C -> count=1, underflow pulses, next read returns 0x3C.
4. Fill to 4, then 20 cycles of simultaneous rd+wr with incrementing din -> count holds 4. Output order is strictly FIFO across pointer wrap.
5. Fill to 5, assert rst with wr_en=1 -> next cycle count=0, empty=1, dout=0, all flags cleared. Subsequent write/read of 0x5A returns 0x5A.
6. With FIFO_FWFT_EN defined: write 0x77 -> dout=0x77 the cycle after the write with no rd_en. Then rd_en for 1 cycle -> empty=1 next cycle.
